seq_mult_4x4: RTL
=================

SEQ_MULT_4X4 -- requirements
Module: seq_mult_4x4

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL expose: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 The block SHALL expose: start  input  1  request to begin a multiply; accepted only in IDLE.
REQ-004 The block SHALL expose: a  input  4  unsigned multiplicand, sampled on the accepting edge.
REQ-005 The block SHALL expose: b  input  4  unsigned multiplier, sampled on the accepting edge.
REQ-006 The block SHALL expose: p  output  8  unsigned product, registered, held until the next accepted start.
REQ-007 The block SHALL expose: busy  output  1  high while an iteration is in progress.
REQ-008 The block SHALL expose: done  output  1  one-cycle pulse marking p valid.
REQ-009 The block SHALL have no parameters; all widths are fixed at 4x4 -> 8.

Function
REQ-010 The block SHALL have exactly one clock, clk; reset is synchronous and active-low on rst_n.
REQ-011 Internal registers SHALL be: M (4b multiplicand), A (4b accumulator), Q (4b multiplier/low product), cnt (2b), and the state.
REQ-012 The block SHALL compute A+M with one instance of the team's 4-bit ripple adder, cin tied to 0; sum s and carry co feed the datapath.
REQ-013 FSM states SHALL be IDLE, CALC, DONE; encoding is free.
REQ-014 IDLE with start=1 at an edge: M<=a, Q<=b, A<=0, cnt<=0, state<=CALC; p is not modified.
REQ-015 IDLE with start=0: all registers hold.
REQ-016 CALC, each edge: if Q[0]=1 then {A,Q} <= {co, s, Q[3:1]} (the 9-bit {co,s,Q} shifted right by 1); else {A,Q} <= {1'b0, A, Q[3:1]}; cnt<=cnt+1.
REQ-017 CALC with cnt=3: the iteration of REQ-016 completes, p <= the resulting {A,Q}, done<=1, state<=DONE.
REQ-018 DONE: lasts exactly one cycle; next edge state<=IDLE, done<=0; start is ignored in DONE.
REQ-019 busy SHALL be 1 exactly while state=CALC (4 cycles per operation).
REQ-020 Latency: done SHALL rise on the 4th rising edge after the edge that accepted start; p valid the same cycle.
REQ-021 start while busy or in DONE SHALL be ignored with no effect on M, A, Q, cnt or p.
REQ-022 Minimum start-to-start spacing SHALL be 6 cycles (accept, 4 CALC, DONE, then IDLE accepts).
REQ-023 The product SHALL equal a*b for all 256 input pairs; no overflow is possible.

Reset
REQ-024 rst_n=0 at an edge SHALL force state=IDLE, p=0, busy=0, done=0, M=A=Q=0, cnt=0, regardless of state.
REQ-025 Reset mid-operation SHALL abort the multiply; no done pulse is produced for the aborted operation.
REQ-026 rst_n=0 SHALL take priority over start on the same edge.

Configuration
REQ-027 With macro SEQ_MULT_BUSY_ERR_EN defined, the block SHALL add output err (1 bit, registered): err=1 for one cycle following any edge where start=1 and state is CALC or DONE; err resets to 0.
REQ-028 Without SEQ_MULT_BUSY_ERR_EN, port err SHALL not exist and ignored starts are silent; all other behaviour is identical.

Verification
REQ-029 Reset, then a=4'hF, b=4'hF, start pulse -> busy high 4 cycles, done pulse 4 edges after accept, p=8'hE1.
REQ-030 a=4'hD, b=4'hB -> p=8'h8F; then a=4'h0, b=4'h9 -> p=8'h00; then a=4'h9, b=4'h0 -> p=8'h00.
REQ-031 Start a=4'h3, b=4'h5; pulse start with a=4'hF, b=4'hF in 2nd CALC cycle -> p=8'h0F, only one done; with SEQ_MULT_BUSY_ERR_EN, err=1 for one cycle.
REQ-032 Start a=4'h7, b=4'h7, assert rst_n=0 in 3rd CALC cycle -> next cycle p=0, busy=0, done never pulses; new start a=4'h2, b=4'h6 -> p=8'h0C.
REQ-033 Start held high continuously with a=4'h5, b=4'h3 -> operations every 6 cycles, each p=8'h0F, done pulses 6 cycles apart.
REQ-034 Exhaustive sweep of all 256 (a,b) pairs -> p equals a*b each time, done exactly once per accepted start.

Source files
------------

// File: rtl/seq_mult_4x4.sv
// 4x4 unsigned shift-and-add multiplier: one add/shift step per clock, four steps per product.
// Define SEQ_MULT_BUSY_ERR_EN to add the registered err output flagging starts that arrive while busy.

module ripple_add4 (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    always_comb begin : ripple
        logic c;
        c = cin_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i] = x_i[i] ^ y_i[i] ^ c;
            c      = (x_i[i] & y_i[i]) | (c & (x_i[i] ^ y_i[i]));
        end
        co_o = c;
    end
endmodule

module seq_mult_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p,
    output logic       busy,
`ifdef SEQ_MULT_BUSY_ERR_EN
    output logic       err,
`endif
    output logic       done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q;
    logic [3:0] m_q;
    logic [3:0] a_q;
    logic [3:0] q_q;
    logic [1:0] cnt_q;
    logic [7:0] p_q;
    logic       busy_q;
    logic       done_q;

    logic [3:0] sum;
    logic       co;
    logic [7:0] aq_d;

    ripple_add4 u_add (
        .x_i  (a_q),
        .y_i  (m_q),
        .cin_i(1'b0),
        .s_o  (sum),
        .co_o (co)
    );

    // One step: optionally add M into A, then shift the 9-bit {carry, A, Q} right by one.
    always_comb begin
        aq_d = q_q[0] ? {co, sum, q_q[3:1]} : {1'b0, a_q, q_q[3:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= 4'd0;
            a_q     <= 4'd0;
            q_q     <= 4'd0;
            cnt_q   <= 2'd0;
            p_q     <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        a_q     <= 4'd0;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    {a_q, q_q} <= aq_d;
                    cnt_q      <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        p_q     <= aq_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_MULT_BUSY_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start && (state_q == CALC || state_q == DONE);
        end
    end

    assign err = err_q;
`endif

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
